inst_sram_like_slave: RTL and testbench

//  Responder end of the SRAM-like instruction port driven by the fetch stage.

---
 rtl/inst_sram_like_slave_pkg.sv | 22 ++
 rtl/inst_sram_like_slave_rsp_pipe.sv | 49 ++++
 rtl/inst_sram_like_slave.sv | 111 +++++++++++
 tb/tb_inst_sram_like_slave.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_sram_like_slave_pkg.sv
// Shared definitions for the SRAM-like instruction port responder.
// Word widths, boot address, address-FSM state type and a counter sizing helper.
package inst_sram_like_slave_pkg;

    localparam int INST_W = 32;
    localparam int DATA_W = 32;

    // Boot fetch address; benches reuse it as a base for stimulus.
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_READY
    } addr_st_e;

    // Bits needed to hold the values 0..d (at least one bit).
    function automatic int cnt_width(input int d);
        return (d < 1) ? 1 : $clog2(d + 1);
    endfunction

endpackage

// File: rtl/inst_sram_like_slave_rsp_pipe.sv
// Response pipe: RD_LATENCY-deep valid/data shift register behind a 1-cycle RAM.
// Ports: clk, resetn (sync, active-low), vld_in (handshake), ram_rdata -> data_ok, rdata.
module inst_sram_like_slave_rsp_pipe
    import inst_sram_like_slave_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              vld_in,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              data_ok,
    output logic [DATA_W-1:0] rdata
);

    logic [RD_LATENCY-1:0] vld_q;

    generate
        if (RD_LATENCY == 1) begin : g_lat1
            // RAM output is already aligned with the response cycle.
            always_ff @(posedge clk) begin
                if (!resetn) vld_q <= '0;
                else         vld_q <= vld_in;
            end

            assign data_ok = vld_q[0];
            assign rdata   = vld_q[0] ? ram_rdata : '0;
        end else begin : g_latn
            logic [DATA_W-1:0] dat_q [1:RD_LATENCY-1];

            always_ff @(posedge clk) begin
                if (!resetn) vld_q <= '0;
                else         vld_q <= {vld_q[RD_LATENCY-2:0], vld_in};
            end

            // Data stages need no reset: they are only observed under valid.
            always_ff @(posedge clk) begin
                dat_q[1] <= ram_rdata;
                for (int i = 2; i < RD_LATENCY; i++) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end

            assign data_ok = vld_q[RD_LATENCY-1];
            assign rdata   = data_ok ? dat_q[RD_LATENCY-1] : '0;
        end
    endgenerate

endmodule

// File: rtl/inst_sram_like_slave.sv
// SRAM-like instruction port responder in front of a synchronous word RAM.
// Ports: clk, resetn, inst_req/inst_addr/inst_addr_ok, inst_rdata/inst_data_ok,
//        ram_en/ram_addr/ram_rdata. In-order responses after RD_LATENCY cycles.
module inst_sram_like_slave
    import inst_sram_like_slave_pkg::*;
#(
    parameter int RAM_AW     = 10,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_DELAY = 0,
    parameter int MAX_OUTST  = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [INST_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,
    output logic              ram_en,
    output logic [RAM_AW-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int CW = cnt_width(ADDR_DELAY);
    localparam int OW = 3;

    generate
        if (RD_LATENCY < 1) begin : g_bad_lat
            $error("inst_sram_like_slave: RD_LATENCY must be >= 1");
        end
        if (MAX_OUTST < 1 || MAX_OUTST > 4) begin : g_bad_outst
            $error("inst_sram_like_slave: MAX_OUTST must be 1..4");
        end
    endgenerate

    addr_st_e      state;
    logic [CW-1:0] dly_cnt;
    logic [OW-1:0] outst;
    logic          ready;
    logic          room;
    logic          hs;

    // With no delay the port is ready whenever a request is present.
    assign ready = (state == ST_READY) || (ADDR_DELAY == 0);

    // A response retiring this cycle frees its slot immediately.
    assign room = (outst < OW'(MAX_OUTST)) || inst_data_ok;

    assign inst_addr_ok = resetn & inst_req & ready & room;
    assign hs           = inst_req & inst_addr_ok;

    assign ram_en   = hs;
    assign ram_addr = inst_addr[RAM_AW+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, inst_addr[INST_W-1:RAM_AW+2], inst_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= ST_IDLE;
            dly_cnt <= CW'(ADDR_DELAY);
        end else if (!inst_req || hs) begin
            // Every request, and every abandoned request, restarts the delay.
            state   <= ST_IDLE;
            dly_cnt <= CW'(ADDR_DELAY);
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ADDR_DELAY == 0 || dly_cnt == CW'(1)) state <= ST_READY;
                    else                                     state <= ST_WAIT;
                    if (dly_cnt != '0) dly_cnt <= dly_cnt - CW'(1);
                end
                ST_WAIT: begin
                    if (dly_cnt == CW'(1)) state <= ST_READY;
                    dly_cnt <= dly_cnt - CW'(1);
                end
                ST_READY: begin
                    // Held off by the outstanding limit; keep waiting.
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            outst <= '0;
        end else begin
            case ({hs, inst_data_ok})
                2'b10:   outst <= outst + OW'(1);
                2'b01:   outst <= outst - OW'(1);
                default: outst <= outst;
            endcase
        end
    end

    inst_sram_like_slave_rsp_pipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rsp_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .vld_in    (hs),
        .ram_rdata (ram_rdata),
        .data_ok   (inst_data_ok),
        .rdata     (inst_rdata)
    );

endmodule

// File: tb/tb_inst_sram_like_slave.sv
// Self-checking bench for inst_sram_like_slave across four parameter sets.
// Expected words are queued at each handshake and compared on inst_data_ok.
module tb_inst_sram_like_slave;

    logic clk;
    logic resetn;

    logic        req_a, aok_a, dok_a, ren_a;
    logic [31:0] addr_a, rdata_a, rram_a;
    logic [9:0]  raddr_a;
    logic        req_b, aok_b, dok_b, ren_b;
    logic [31:0] addr_b, rdata_b, rram_b;
    logic [9:0]  raddr_b;
    logic        req_c, aok_c, dok_c, ren_c;
    logic [31:0] addr_c, rdata_c, rram_c;
    logic [9:0]  raddr_c;
    logic        req_d, aok_d, dok_d, ren_d;
    logic [31:0] addr_d, rdata_d, rram_d;
    logic [9:0]  raddr_d;

    int          checks;
    int          errors;
    logic [31:0] q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [9:0] idx);
        if (idx == 10'h00D) return 32'h2402_0005;
        return {16'hC0DE, 6'b0, idx};
    endfunction

    // Synchronous 1-cycle RAM models.
    always_ff @(posedge clk) if (ren_a) rram_a <= word_of(raddr_a);
    always_ff @(posedge clk) if (ren_b) rram_b <= word_of(raddr_b);
    always_ff @(posedge clk) if (ren_c) rram_c <= word_of(raddr_c);
    always_ff @(posedge clk) if (ren_d) rram_d <= word_of(raddr_d);

    inst_sram_like_slave #(.RAM_AW(10), .RD_LATENCY(1), .ADDR_DELAY(0), .MAX_OUTST(2)) u_a (
        .clk(clk), .resetn(resetn), .inst_req(req_a), .inst_addr(addr_a),
        .inst_addr_ok(aok_a), .inst_rdata(rdata_a), .inst_data_ok(dok_a),
        .ram_en(ren_a), .ram_addr(raddr_a), .ram_rdata(rram_a));

    inst_sram_like_slave #(.RAM_AW(10), .RD_LATENCY(2), .ADDR_DELAY(0), .MAX_OUTST(2)) u_b (
        .clk(clk), .resetn(resetn), .inst_req(req_b), .inst_addr(addr_b),
        .inst_addr_ok(aok_b), .inst_rdata(rdata_b), .inst_data_ok(dok_b),
        .ram_en(ren_b), .ram_addr(raddr_b), .ram_rdata(rram_b));

    inst_sram_like_slave #(.RAM_AW(10), .RD_LATENCY(3), .ADDR_DELAY(0), .MAX_OUTST(1)) u_c (
        .clk(clk), .resetn(resetn), .inst_req(req_c), .inst_addr(addr_c),
        .inst_addr_ok(aok_c), .inst_rdata(rdata_c), .inst_data_ok(dok_c),
        .ram_en(ren_c), .ram_addr(raddr_c), .ram_rdata(rram_c));

    inst_sram_like_slave #(.RAM_AW(10), .RD_LATENCY(1), .ADDR_DELAY(2), .MAX_OUTST(2)) u_d (
        .clk(clk), .resetn(resetn), .inst_req(req_d), .inst_addr(addr_d),
        .inst_addr_ok(aok_d), .inst_rdata(rdata_d), .inst_data_ok(dok_d),
        .ram_en(ren_d), .ram_addr(raddr_d), .ram_rdata(rram_d));

    task automatic test_reset();
        resetn = 1'b0;
        req_a = 1'b1; req_b = 1'b1; req_c = 1'b1; req_d = 1'b1;
        addr_a = 32'h34; addr_b = 32'h34; addr_c = 32'h34; addr_d = 32'h34;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if ({aok_a, dok_a, ren_a} !== 3'b000 || rdata_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_a cyc%0d: aok/dok/en=%b%b%b rdata=%h, required 000 rdata=0",
                         c, aok_a, dok_a, ren_a, rdata_a);
            end
            checks++;
            if ({aok_b, dok_b, ren_b} !== 3'b000 || rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_b cyc%0d: aok/dok/en=%b%b%b rdata=%h, required 000 rdata=0",
                         c, aok_b, dok_b, ren_b, rdata_b);
            end
            checks++;
            if ({aok_d, dok_d, ren_d} !== 3'b000) begin
                errors++;
                $display("FAIL reset_d cyc%0d: aok/dok/en=%b%b%b, required 000",
                         c, aok_d, dok_d, ren_d);
            end
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; req_d = 1'b0;
    endtask

    task automatic test_single_read();
        @(posedge clk); #1;
        req_a = 1'b1; addr_a = 32'h34;
        @(negedge clk);
        checks++;
        if (aok_a !== 1'b1) begin
            errors++;
            $display("FAIL single_aok: got %b, required 1", aok_a);
        end
        checks++;
        if (ren_a !== 1'b1 || raddr_a !== 10'h00D) begin
            errors++;
            $display("FAIL single_ram: en=%b addr=%h, required en=1 addr=00d", ren_a, raddr_a);
        end
        @(posedge clk); #1;
        req_a = 1'b0;
        @(negedge clk);
        checks++;
        if (dok_a !== 1'b1 || rdata_a !== 32'h2402_0005) begin
            errors++;
            $display("FAIL single_data: dok=%b rdata=%h, required dok=1 rdata=24020005",
                     dok_a, rdata_a);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (dok_a !== 1'b0 || rdata_a !== 32'h0) begin
                errors++;
                $display("FAIL single_after cyc%0d: dok=%b rdata=%h, required 0/0",
                         c, dok_a, rdata_a);
            end
        end
    endtask

    task automatic test_wrap_misaligned();
        logic [31:0] exp;
        int          ok_n;
        ok_n = 0;
        q.delete();
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            req_a  = (c == 0);
            addr_a = 32'hFFFF_F037;
            @(negedge clk);
            if (dok_a) begin
                ok_n++;
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                if (rdata_a !== exp) begin
                    errors++;
                    $display("FAIL wrap_data: got %h, required %h", rdata_a, exp);
                end
            end
            if (req_a && aok_a) begin
                q.push_back(word_of(addr_a[11:2]));
                checks++;
                if (raddr_a !== 10'h00D) begin
                    errors++;
                    $display("FAIL wrap_addr: got %h, required 00d", raddr_a);
                end
            end
        end
        checks++;
        if (ok_n != 1 || q.size() != 0) begin
            errors++;
            $display("FAIL wrap_count: responses=%0d left=%0d, required 1/0", ok_n, q.size());
        end
    endtask

    task automatic test_streaming();
        logic [31:0] exp;
        int          hs_n, ok_n, first_ok, last_ok;
        hs_n = 0; ok_n = 0; first_ok = -1; last_ok = -1;
        q.delete();
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            req_b  = (c < 3);
            addr_b = 32'h34 + 32'(4 * c);
            @(negedge clk);
            if (c < 3) begin
                checks++;
                if (aok_b !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_aok cyc%0d: got %b, required 1", c, aok_b);
                end
            end
            if (dok_b) begin
                ok_n++;
                if (first_ok < 0) first_ok = c;
                last_ok = c;
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                if (rdata_b !== exp) begin
                    errors++;
                    $display("FAIL stream_data cyc%0d: got %h, required %h", c, rdata_b, exp);
                end
            end
            if (req_b && aok_b) begin
                hs_n++;
                q.push_back(word_of(addr_b[11:2]));
            end
        end
        checks++;
        if (hs_n != 3 || ok_n != 3) begin
            errors++;
            $display("FAIL stream_count: hs=%0d ok=%0d, required 3/3", hs_n, ok_n);
        end
        checks++;
        if (first_ok != 2 || last_ok != 4) begin
            errors++;
            $display("FAIL stream_timing: first=%0d last=%0d, required 2/4", first_ok, last_ok);
        end
    endtask

    task automatic test_throttle();
        logic [31:0] exp;
        int          k, hs_n, prev_hs;
        k = 0; hs_n = 0; prev_hs = -1;
        q.delete();
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            req_c  = (c < 12);
            addr_c = 32'h40 + 32'(4 * k);
            @(negedge clk);
            if (dok_c) begin
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                if (rdata_c !== exp) begin
                    errors++;
                    $display("FAIL throttle_data cyc%0d: got %h, required %h", c, rdata_c, exp);
                end
            end
            if (req_c && aok_c) begin
                hs_n++;
                k++;
                q.push_back(word_of(addr_c[11:2]));
                checks++;
                if (c != 3 * (hs_n - 1) || q.size() > 1) begin
                    errors++;
                    $display("FAIL throttle_hs: at cyc%0d prev=%0d pending=%0d, required cyc%0d pending<=1",
                             c, prev_hs, q.size(), 3 * (hs_n - 1));
                end
                prev_hs = c;
            end
        end
        checks++;
        if (hs_n != 4 || q.size() != 0) begin
            errors++;
            $display("FAIL throttle_count: hs=%0d left=%0d, required 4/0", hs_n, q.size());
        end
    endtask

    task automatic test_delay();
        logic [0:10] rp;
        logic [0:10] ea;
        logic [31:0] exp;
        int          ok_n;
        rp = 11'b111_0101_1100;
        ea = 11'b001_0000_0100;
        ok_n = 0;
        q.delete();
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            req_d  = rp[c];
            addr_d = (c < 4) ? 32'h40 : 32'h43;
            @(negedge clk);
            checks++;
            if (aok_d !== ea[c]) begin
                errors++;
                $display("FAIL delay_aok cyc%0d: got %b, required %b", c, aok_d, ea[c]);
            end
            if (dok_d) begin
                ok_n++;
                checks++;
                exp = (q.size() != 0) ? q.pop_front() : 32'hDEAD_BEEF;
                if (rdata_d !== exp) begin
                    errors++;
                    $display("FAIL delay_data cyc%0d: got %h, required %h", c, rdata_d, exp);
                end
            end
            if (req_d && aok_d) q.push_back(word_of(addr_d[11:2]));
        end
        checks++;
        if (ok_n != 2) begin
            errors++;
            $display("FAIL delay_count: responses=%0d, required 2", ok_n);
        end
    endtask

    task automatic test_reset_midflight();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            req_b  = 1'b1;
            addr_b = 32'h34 + 32'(4 * c);
            @(negedge clk);
            checks++;
            if (aok_b !== 1'b1) begin
                errors++;
                $display("FAIL mid_aok cyc%0d: got %b, required 1", c, aok_b);
            end
        end
        @(posedge clk); #1;
        req_b  = 1'b0;
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (dok_b !== 1'b0) begin
                errors++;
                $display("FAIL mid_flush cyc%0d: dok=%b, required 0", c, dok_b);
            end
        end
        @(posedge clk); #1;
        req_b  = 1'b1;
        addr_b = 32'h3C;
        @(negedge clk);
        checks++;
        if (aok_b !== 1'b1) begin
            errors++;
            $display("FAIL mid_new_aok: got %b, required 1", aok_b);
        end
        @(posedge clk); #1;
        req_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dok_b !== 1'b1 || rdata_b !== word_of(10'h00F)) begin
            errors++;
            $display("FAIL mid_new_data: dok=%b rdata=%h, required 1/%h",
                     dok_b, rdata_b, word_of(10'h00F));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0; req_d = 1'b0;
        addr_a = '0; addr_b = '0; addr_c = '0; addr_d = '0;
        test_reset();
        test_single_read();
        test_wrap_misaligned();
        test_streaming();
        test_throttle();
        test_delay();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
